// File: rtl/operand_fetch_unit.sv
// operand_fetch_unit: resolves one operand-fetch request (IMM/DIR/INDIR/REG)
// against a combinational register file and a pipelined synchronous RAM, and
// returns the value on a valid/ready response channel.
//
// Optional feature macro: OFU_ADDR_CHECK_EN. When defined, DIR/INDIR addresses
// with nonzero bits above RAM_ADDR_WIDTH are faulted (rsp_err=1, rsp_data=0,
// no RAM strobe). When undefined, addresses are truncated and rsp_err stays 0.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   req_valid/req_ready      request handshake; req_mode, req_operand payload
//   reg_addr/reg_data        register file read (data combinational from addr)
//   ram_rd_en/ram_addr       one-cycle RAM read strobe and address
//   ram_data                 RAM data, valid RAM_LATENCY cycles after strobe
//   rsp_valid/rsp_ready      response handshake; rsp_data, rsp_err payload
//   busy                     high whenever the unit is not idle
module operand_fetch_unit #(
  parameter int unsigned MODE_WIDTH     = 2,
  parameter int unsigned RAM_DATA_WIDTH = 8,
  parameter int unsigned RAM_ADDR_WIDTH = 8,
  parameter int unsigned REG_DATA_WIDTH = 8,
  parameter int unsigned REG_ADDR_WIDTH = 4,
  parameter int unsigned OPERAND_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned RAM_LATENCY    = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [MODE_WIDTH-1:0]     req_mode,
  input  logic [OPERAND_WIDTH-1:0]  req_operand,
  output logic [REG_ADDR_WIDTH-1:0] reg_addr,
  input  logic [REG_DATA_WIDTH-1:0] reg_data,
  output logic                      ram_rd_en,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
  input  logic [RAM_DATA_WIDTH-1:0] ram_data,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_data,
  output logic                      rsp_err,
  output logic                      busy
);

  localparam int unsigned CNT_W = 3;

  localparam logic [MODE_WIDTH-1:0] MODE_IMM   = MODE_WIDTH'(0);
  localparam logic [MODE_WIDTH-1:0] MODE_DIR   = MODE_WIDTH'(1);
  localparam logic [MODE_WIDTH-1:0] MODE_INDIR = MODE_WIDTH'(2);
  localparam logic [MODE_WIDTH-1:0] MODE_REG   = MODE_WIDTH'(3);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REG_RD   = 3'd1,
    RAM_RD   = 3'd2,
    RAM_WAIT = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t                    state_q, state_d;
  logic [MODE_WIDTH-1:0]     mode_q, mode_d;
  logic                      fault_q, fault_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      req_ready_q, req_ready_d;
  logic                      busy_q, busy_d;
  logic [REG_ADDR_WIDTH-1:0] reg_addr_q, reg_addr_d;
  logic                      ram_rd_en_q, ram_rd_en_d;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]     rsp_data_q, rsp_data_d;
  logic                      rsp_err_q, rsp_err_d;

  // Address-range faults; only meaningful when the source is wider than the RAM address.
  logic dir_fault_c, ind_fault_c;
`ifdef OFU_ADDR_CHECK_EN
  if (OPERAND_WIDTH > RAM_ADDR_WIDTH) begin : g_dir_chk
    assign dir_fault_c = |req_operand[OPERAND_WIDTH-1:RAM_ADDR_WIDTH];
  end else begin : g_dir_nochk
    assign dir_fault_c = 1'b0;
  end
  if (REG_DATA_WIDTH > RAM_ADDR_WIDTH) begin : g_ind_chk
    assign ind_fault_c = |reg_data[REG_DATA_WIDTH-1:RAM_ADDR_WIDTH];
  end else begin : g_ind_nochk
    assign ind_fault_c = 1'b0;
  end
`else
  assign dir_fault_c = 1'b0;
  assign ind_fault_c = 1'b0;
`endif

  // Next-state and next-output decode; addresses default to 0 when unused.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    fault_d     = fault_q;
    cnt_d       = cnt_q;
    reg_addr_d  = '0;
    ram_rd_en_d = 1'b0;
    ram_addr_d  = '0;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          mode_d  = req_mode;
          fault_d = 1'b0;
          cnt_d   = '0;
          case (req_mode)
            MODE_REG, MODE_INDIR: begin
              state_d    = REG_RD;
              reg_addr_d = REG_ADDR_WIDTH'(req_operand);
            end
            MODE_DIR: begin
              state_d = RAM_RD;
              if (dir_fault_c) begin
                fault_d = 1'b1;
              end else begin
                ram_rd_en_d = 1'b1;
                ram_addr_d  = RAM_ADDR_WIDTH'(req_operand);
              end
            end
            default: begin
              state_d     = DONE;
              rsp_valid_d = 1'b1;
              rsp_data_d  = DATA_WIDTH'(req_operand);
              rsp_err_d   = 1'b0;
            end
          endcase
        end
      end
      REG_RD: begin
        if (mode_q == MODE_REG) begin
          state_d     = DONE;
          rsp_valid_d = 1'b1;
          rsp_data_d  = DATA_WIDTH'(reg_data);
          rsp_err_d   = 1'b0;
        end else begin
          state_d = RAM_RD;
          if (ind_fault_c) begin
            fault_d = 1'b1;
          end else begin
            ram_rd_en_d = 1'b1;
            ram_addr_d  = RAM_ADDR_WIDTH'(reg_data);
          end
        end
      end
      RAM_RD: begin
        // A faulted fetch passes through here without a strobe and reports the error.
        if (fault_q) begin
          state_d     = DONE;
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
        end else begin
          state_d = RAM_WAIT;
          cnt_d   = '0;
        end
      end
      RAM_WAIT: begin
        if (cnt_q == CNT_W'(RAM_LATENCY - 1)) begin
          state_d     = DONE;
          rsp_valid_d = 1'b1;
          rsp_data_d  = DATA_WIDTH'(ram_data);
          rsp_err_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= '0;
      fault_q     <= 1'b0;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      reg_addr_q  <= '0;
      ram_rd_en_q <= 1'b0;
      ram_addr_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      fault_q     <= fault_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      reg_addr_q  <= reg_addr_d;
      ram_rd_en_q <= ram_rd_en_d;
      ram_addr_q  <= ram_addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign reg_addr  = reg_addr_q;
  assign ram_rd_en = ram_rd_en_q;
  assign ram_addr  = ram_addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Directed bench for operand_fetch_unit: two instances (RAM_LATENCY 1 and 2)
// share request/response-ready stimulus; each has its own RAM pipeline model.
// With OFU_ADDR_CHECK_EN a third instance (RAM_ADDR_WIDTH=6) checks faulting.
module tb_operand_fetch_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [1:0] req_mode;
  logic [7:0] req_operand;
  logic       rsp_ready;

  logic [7:0] rf  [16];
  logic [7:0] mem [256];

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  // Instance with RAM_LATENCY = 1
  logic       req_ready_l1, ram_rd_en_l1, rsp_valid_l1, rsp_err_l1, busy_l1;
  logic [3:0] reg_addr_l1;
  logic [7:0] reg_data_l1, ram_addr_l1, ram_data_l1, rsp_data_l1, p1_s0;
  int         n_rd1 = 0;

  operand_fetch_unit #(.RAM_LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_l1),
    .req_mode(req_mode), .req_operand(req_operand), .reg_addr(reg_addr_l1),
    .reg_data(reg_data_l1), .ram_rd_en(ram_rd_en_l1), .ram_addr(ram_addr_l1),
    .ram_data(ram_data_l1), .rsp_valid(rsp_valid_l1), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data_l1), .rsp_err(rsp_err_l1), .busy(busy_l1)
  );

  assign reg_data_l1 = rf[reg_addr_l1];
  always @(posedge clk) begin
    p1_s0 <= ram_rd_en_l1 ? mem[ram_addr_l1] : 8'h00;
    if (ram_rd_en_l1) n_rd1 <= n_rd1 + 1;
  end
  assign ram_data_l1 = p1_s0;

  // Instance with RAM_LATENCY = 2
  logic       req_ready_l2, ram_rd_en_l2, rsp_valid_l2, rsp_err_l2, busy_l2;
  logic [3:0] reg_addr_l2;
  logic [7:0] reg_data_l2, ram_addr_l2, ram_data_l2, rsp_data_l2, p2_s0, p2_s1;
  int         n_rd2 = 0;

  operand_fetch_unit #(.RAM_LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_l2),
    .req_mode(req_mode), .req_operand(req_operand), .reg_addr(reg_addr_l2),
    .reg_data(reg_data_l2), .ram_rd_en(ram_rd_en_l2), .ram_addr(ram_addr_l2),
    .ram_data(ram_data_l2), .rsp_valid(rsp_valid_l2), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data_l2), .rsp_err(rsp_err_l2), .busy(busy_l2)
  );

  assign reg_data_l2 = rf[reg_addr_l2];
  always @(posedge clk) begin
    p2_s0 <= ram_rd_en_l2 ? mem[ram_addr_l2] : 8'h00;
    p2_s1 <= p2_s0;
    if (ram_rd_en_l2) n_rd2 <= n_rd2 + 1;
  end
  assign ram_data_l2 = p2_s1;

`ifdef OFU_ADDR_CHECK_EN
  // Instance with a 6-bit RAM address for the address-range check
  logic       req_ready_ck, ram_rd_en_ck, rsp_valid_ck, rsp_err_ck, busy_ck;
  logic [3:0] reg_addr_ck;
  logic [5:0] ram_addr_ck;
  logic [7:0] reg_data_ck, ram_data_ck, rsp_data_ck, pc_s0;
  int         n_rdc = 0;

  operand_fetch_unit #(.RAM_ADDR_WIDTH(6), .RAM_LATENCY(1)) u_ck (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_ck),
    .req_mode(req_mode), .req_operand(req_operand), .reg_addr(reg_addr_ck),
    .reg_data(reg_data_ck), .ram_rd_en(ram_rd_en_ck), .ram_addr(ram_addr_ck),
    .ram_data(ram_data_ck), .rsp_valid(rsp_valid_ck), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data_ck), .rsp_err(rsp_err_ck), .busy(busy_ck)
  );

  assign reg_data_ck = rf[reg_addr_ck];
  always @(posedge clk) begin
    pc_s0 <= ram_rd_en_ck ? mem[{2'b00, ram_addr_ck}] : 8'h00;
    if (ram_rd_en_ck) n_rdc <= n_rdc + 1;
  end
  assign ram_data_ck = pc_s0;
`endif

  // Packed view of every output: {req_ready, rsp_valid, rsp_err, busy, ram_rd_en, ram_addr, reg_addr, rsp_data}
  logic [31:0] o1, o2;
  assign o1 = {7'h0, req_ready_l1, rsp_valid_l1, rsp_err_l1, busy_l1, ram_rd_en_l1,
               ram_addr_l1, reg_addr_l1, rsp_data_l1};
  assign o2 = {7'h0, req_ready_l2, rsp_valid_l2, rsp_err_l2, busy_l2, ram_rd_en_l2,
               ram_addr_l2, reg_addr_l2, rsp_data_l2};
  localparam logic [31:0] RST_V = 32'h0100_0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int n0, m0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < 16; i++) rf[i] = 8'h00;
    rf[3] = 8'h5C; rf[2] = 8'h10;
    mem[8'h40] = 8'h77; mem[8'h10] = 8'hEE;

    rst = 1'b1; req_valid = 1'b0; req_mode = 2'b00; req_operand = 8'h00; rsp_ready = 1'b1;
    #2;
    chk("reset_l1", o1, RST_V);
    chk("reset_l2", o2, RST_V);
    tick(); tick();
    rst = 1'b0;
    tick();

    // IMM 0xA5: response at T+1, no RAM strobe
    n0 = n_rd1; m0 = n_rd2;
    req_mode = 2'b00; req_operand = 8'hA5; req_valid = 1'b1;
    chk("imm_req_ready", {31'h0, req_ready_l1}, 32'h1);
    tick(); req_valid = 1'b0;
    chk("imm_t1_valid", {31'h0, rsp_valid_l1}, 32'h1);
    chk("imm_t1_data_l1", {24'h0, rsp_data_l1}, 32'hA5);
    chk("imm_t1_data_l2", {24'h0, rsp_data_l2}, 32'hA5);
    chk("imm_t1_busy_rdy", {30'h0, busy_l1, req_ready_l1}, 32'h2);
    tick();
    chk("imm_t2_idle", {30'h0, rsp_valid_l1, req_ready_l1}, 32'h1);
    chk("imm_no_strobe", 32'(n_rd1 - n0 + n_rd2 - m0), 32'h0);

    // REG r3 = 0x5C: reg_addr at T+1, response at T+2
    req_mode = 2'b11; req_operand = 8'h03; req_valid = 1'b1;
    tick(); req_valid = 1'b0;
    chk("reg_t1_addr", {28'h0, reg_addr_l1}, 32'h3);
    chk("reg_t1_valid", {31'h0, rsp_valid_l1}, 32'h0);
    tick();
    chk("reg_t2_valid", {31'h0, rsp_valid_l1}, 32'h1);
    chk("reg_t2_data", {24'h0, rsp_data_l1}, 32'h5C);
    chk("reg_t2_addr0", {28'h0, reg_addr_l1}, 32'h0);
    tick();
    chk("reg_t3_idle", {31'h0, rsp_valid_l2}, 32'h0);
    chk("reg_no_strobe", 32'(n_rd1 - n0 + n_rd2 - m0), 32'h0);

    // DIR 0x40 -> 0x77: strobe at T+1; L1 responds T+3, L2 responds T+4
    n0 = n_rd1; m0 = n_rd2;
    req_mode = 2'b01; req_operand = 8'h40; req_valid = 1'b1;
    tick(); req_valid = 1'b0;
    chk("dir_t1_strobe_l1", {23'h0, ram_rd_en_l1, ram_addr_l1}, 32'h140);
    chk("dir_t1_strobe_l2", {23'h0, ram_rd_en_l2, ram_addr_l2}, 32'h140);
    tick();
    chk("dir_t2_nostrobe", {22'h0, ram_rd_en_l1, ram_rd_en_l2, ram_addr_l2}, 32'h0);
    tick();
    chk("dir_t3_l1", {22'h0, rsp_valid_l1, rsp_err_l1, rsp_data_l1}, 32'h277);
    chk("dir_t3_l2_wait", {31'h0, rsp_valid_l2}, 32'h0);
    tick();
    chk("dir_t4_l2", {22'h0, rsp_valid_l2, rsp_err_l2, rsp_data_l2}, 32'h277);
    chk("dir_t4_l1_done", {30'h0, rsp_valid_l1, req_ready_l1}, 32'h1);
    tick();
    chk("dir_t5_l2_idle", {30'h0, rsp_valid_l2, req_ready_l2}, 32'h1);
    chk("dir_one_strobe", {16'h0, 8'(n_rd1 - n0), 8'(n_rd2 - m0)}, 32'h0101);

    // INDIR r2 -> 0x10 -> 0xEE with rsp_ready low: L1 valid from T+4, L2 from T+5
    n0 = n_rd1; m0 = n_rd2;
    rsp_ready = 1'b0;
    req_mode = 2'b10; req_operand = 8'h02; req_valid = 1'b1;
    tick(); req_valid = 1'b0;
    chk("ind_t1_regaddr", {27'h0, ram_rd_en_l1, reg_addr_l1}, 32'h2);
    tick();
    chk("ind_t2_strobe", {19'h0, ram_rd_en_l1, ram_addr_l1, reg_addr_l1}, 32'h1100);
    tick();
    chk("ind_t3_valid", {31'h0, rsp_valid_l1}, 32'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("ind_hold_l1", {22'h0, rsp_valid_l1, req_ready_l1, rsp_data_l1}, 32'h2EE);
      tick();
    end
    chk("ind_hold_l2", {22'h0, rsp_valid_l2, req_ready_l2, rsp_data_l2}, 32'h2EE);
    chk("ind_hold_l1_end", {23'h0, rsp_valid_l1, rsp_data_l1}, 32'h1EE);
    rsp_ready = 1'b1;
    tick();
    chk("ind_release", {28'h0, rsp_valid_l1, req_ready_l1, rsp_valid_l2, req_ready_l2}, 32'h5);
    chk("ind_one_strobe", {16'h0, 8'(n_rd1 - n0), 8'(n_rd2 - m0)}, 32'h0101);

    // Reset during RAM_WAIT of a DIR fetch
    req_mode = 2'b01; req_operand = 8'h40; req_valid = 1'b1;
    tick(); req_valid = 1'b0;
    tick();
    chk("mid_busy_l2", {31'h0, busy_l2}, 32'h1);
    rst = 1'b1;
    #1;
    chk("mid_reset_l1", o1, RST_V);
    chk("mid_reset_l2", o2, RST_V);
    tick();
    rst = 1'b0;
    tick();
    chk("mid_no_late_rsp", {30'h0, rsp_valid_l1, rsp_valid_l2}, 32'h0);
    req_mode = 2'b00; req_operand = 8'h01; req_valid = 1'b1;
    tick(); req_valid = 1'b0;
    chk("post_rst_imm_l1", {23'h0, rsp_valid_l1, rsp_data_l1}, 32'h101);
    chk("post_rst_imm_l2", {23'h0, rsp_valid_l2, rsp_data_l2}, 32'h101);
    tick();

`ifdef OFU_ADDR_CHECK_EN
    // DIR 0x80 with a 6-bit RAM address: faulted, no strobe, error at T+2
    n0 = n_rdc;
    req_mode = 2'b01; req_operand = 8'h80; req_valid = 1'b1;
    tick(); req_valid = 1'b0;
    chk("ck_t1_nostrobe", {31'h0, ram_rd_en_ck}, 32'h0);
    tick();
    chk("ck_t2_fault", {22'h0, rsp_valid_ck, rsp_err_ck, rsp_data_ck}, 32'h300);
    chk("ck_no_strobe", 32'(n_rdc - n0), 32'h0);
    for (int i = 0; i < 4; i++) tick();
    chk("ck_others_idle", {30'h0, req_ready_l1, req_ready_l2}, 32'h3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/operand_fetch_unit.md
Name: operand_fetch_unit

Overview:
- Sequential, handshaked successor to the combinational operand selector.
- Accepts one operand-fetch request (addressing mode + operand field) and resolves it against the register file and a pipelined synchronous RAM.
- Returns the fetched value on a valid/ready response channel.
- Sits between the instruction decoder and the ALU operand latch; one request outstanding at a time.

Parameters:
- MODE_WIDTH, 2, width of addressing-mode field.
- RAM_DATA_WIDTH, 8, RAM read data width.
- RAM_ADDR_WIDTH, 8, RAM address width.
- REG_DATA_WIDTH, 8, register file read data width.
- REG_ADDR_WIDTH, 4, register file address width.
- OPERAND_WIDTH, 8, width of instruction operand field.
- DATA_WIDTH, 8, width of fetched result.
- RAM_LATENCY, 1, cycles from ram_rd_en to valid ram_data; legal 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_mode  in  MODE_WIDTH  00 IMM, 01 DIR, 10 INDIR, 11 REG.
- req_operand  in  OPERAND_WIDTH  operand field.
- reg_addr  out  REG_ADDR_WIDTH  register file read address.
- reg_data  in  REG_DATA_WIDTH  register file read data, combinational from reg_addr.
- ram_rd_en  out  1  one-cycle RAM read strobe.
- ram_addr  out  RAM_ADDR_WIDTH  RAM read address, valid while ram_rd_en is high.
- ram_data  in  RAM_DATA_WIDTH  RAM read data, valid RAM_LATENCY cycles after the strobe.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_data  out  DATA_WIDTH  fetched operand.
- rsp_err  out  1  address fault (see Optional Feature).
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset values: state IDLE, req_ready 1, rsp_valid 0, rsp_data 0, rsp_err 0, ram_rd_en 0, ram_addr 0, reg_addr 0, busy 0, wait counter 0.
- Handshakes and registers:
  - req_ready equals (state == IDLE); the request handshake occurs on req_valid && req_ready.
  - Mode and operand are latched on acceptance (cycle T).
  - reg_addr and ram_addr are registered/decoded from latched values only and are 0 when unused.
- States: IDLE, REG_RD, RAM_RD, RAM_WAIT, DONE.
  - IMM: IDLE->DONE; rsp_valid at T+1.
  - REG: IDLE->REG_RD->DONE. In T+1, reg_addr = operand[REG_ADDR_WIDTH-1:0]; reg_data is captured. rsp_valid at T+2.
  - DIR: IDLE->RAM_RD->RAM_WAIT->DONE. In T+1, ram_rd_en=1 and ram_addr = operand[RAM_ADDR_WIDTH-1:0]. RAM_WAIT counts RAM_LATENCY cycles, and ram_data is captured at the end of cycle T+1+RAM_LATENCY. rsp_valid at T+2+RAM_LATENCY.
  - INDIR: IDLE->REG_RD->RAM_RD->RAM_WAIT->DONE. The pointer reg_data is captured in T+1. ram_rd_en with ram_addr = pointer[RAM_ADDR_WIDTH-1:0] in T+2. rsp_valid at T+3+RAM_LATENCY.
- Width rules:
  - All narrowing takes the low bits.
  - Widening to DATA_WIDTH zero-extends.
- DONE behaviour:
  - rsp_valid=1; rsp_data and rsp_err are held stable until rsp_valid && rsp_ready.
  - After the handshake, the next state is IDLE and rsp_valid clears on that edge.
  - No new request is accepted in the same cycle as the response handshake.
- ram_rd_en is high for exactly one cycle per DIR/INDIR request and is never asserted for IMM/REG.
- Asynchronous reset mid-operation:
  - Immediately returns all outputs to reset values.
  - Any RAM read in flight is ignored; no partial response is emitted.
- req_valid while busy has no effect; the request must be held by the producer.

Optional Feature:
- Macro: OFU_ADDR_CHECK_EN.
- When defined, DIR/INDIR whose source address has nonzero bits above RAM_ADDR_WIDTH is faulted:
  - DIR checks operand bits [OPERAND_WIDTH-1:RAM_ADDR_WIDTH].
  - INDIR checks pointer bits [REG_DATA_WIDTH-1:RAM_ADDR_WIDTH].
  - On a fault there is no RAM strobe; the state goes directly to DONE one cycle after the address source is known, with rsp_data=0 and rsp_err=1.
  - The check is inactive when the source width is <= RAM_ADDR_WIDTH.
- When not defined, addresses are silently truncated and rsp_err is tied to 0.

Test Plan:
- Reset, then IMM with operand 0xA5 accepted at T -> rsp_valid at T+1 with rsp_data 0xA5; no ram_rd_en pulse.
- REG with operand 0x3 and reg[3]=0x5C -> reg_addr 3 in T+1; rsp_data 0x5C at T+2.
- DIR with operand 0x40, RAM_LATENCY=2, mem[0x40]=0x77 -> single ram_rd_en at T+1 with ram_addr 0x40; rsp_data 0x77 at T+4.
- INDIR with operand 0x2, reg[2]=0x10, mem[0x10]=0xEE, RAM_LATENCY=1, rsp_ready held low 3 cycles -> rsp_valid from T+4, data 0xEE held stable, req_ready stays 0 until the handshake.
- Assert rst during RAM_WAIT of a DIR fetch -> all outputs 0 and req_ready 1 immediately; the late ram_data is never reported and the next IMM 0x01 returns 0x01.
- With OFU_ADDR_CHECK_EN and RAM_ADDR_WIDTH=6, DIR operand 0x80 -> no ram_rd_en; rsp_err=1 and rsp_data=0 at T+2.
